// File: rtl/ccu_mst_arbiter.sv
// ccu_mst_arbiter: round-robin arbiter that shares one non-pipelined CCU
// coherency port among NoMstPorts ACE masters. It grants one whole transaction
// at a time. AR/AW/W from the granted master go to the CCU, and R/B from the
// CCU go back to that master only.
module ccu_mst_arbiter #(
    parameter int NoMstPorts = 4,
    parameter int ArW        = 64,
    parameter int AwW        = 64,
    parameter int WW         = 73,
    parameter int RW         = 70,
    parameter int BW         = 6,
    localparam int IdxW      = $clog2(NoMstPorts)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // master-side AR
    input  logic [NoMstPorts-1:0]      mst_ar_valid_i,
    output logic [NoMstPorts-1:0]      mst_ar_ready_o,
    input  logic [NoMstPorts*ArW-1:0]  mst_ar_i,
    // master-side AW
    input  logic [NoMstPorts-1:0]      mst_aw_valid_i,
    output logic [NoMstPorts-1:0]      mst_aw_ready_o,
    input  logic [NoMstPorts*AwW-1:0]  mst_aw_i,
    // master-side W
    input  logic [NoMstPorts-1:0]      mst_w_valid_i,
    output logic [NoMstPorts-1:0]      mst_w_ready_o,
    input  logic [NoMstPorts*WW-1:0]   mst_w_i,
    input  logic [NoMstPorts-1:0]      mst_w_last_i,
    // master-side R (payload broadcast)
    output logic [NoMstPorts-1:0]      mst_r_valid_o,
    input  logic [NoMstPorts-1:0]      mst_r_ready_i,
    output logic [RW-1:0]              mst_r_o,
    output logic                       mst_r_last_o,
    // master-side B (payload broadcast)
    output logic [NoMstPorts-1:0]      mst_b_valid_o,
    input  logic [NoMstPorts-1:0]      mst_b_ready_i,
    output logic [BW-1:0]              mst_b_o,
    // CCU-side AR
    output logic                       ccu_ar_valid_o,
    input  logic                       ccu_ar_ready_i,
    output logic [ArW-1:0]             ccu_ar_o,
    // CCU-side AW
    output logic                       ccu_aw_valid_o,
    input  logic                       ccu_aw_ready_i,
    output logic [AwW-1:0]             ccu_aw_o,
    // CCU-side W
    output logic                       ccu_w_valid_o,
    input  logic                       ccu_w_ready_i,
    output logic [WW-1:0]              ccu_w_o,
    output logic                       ccu_w_last_o,
    // CCU-side R
    input  logic                       ccu_r_valid_i,
    output logic                       ccu_r_ready_o,
    input  logic [RW-1:0]              ccu_r_i,
    input  logic                       ccu_r_last_i,
    // CCU-side B
    input  logic                       ccu_b_valid_i,
    output logic                       ccu_b_ready_o,
    input  logic [BW-1:0]              ccu_b_i,
    // status
    output logic                       busy_o,
    output logic [IdxW-1:0]            grant_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic            is_read_q, is_read_d;

    logic [NoMstPorts-1:0] req;
    logic [IdxW-1:0]       pick;

    logic [ArW-1:0] ar_arr [NoMstPorts];
    logic [AwW-1:0] aw_arr [NoMstPorts];
    logic [WW-1:0]  w_arr  [NoMstPorts];

    assign req     = mst_ar_valid_i | mst_aw_valid_i;
    assign busy_o  = (state_q != IDLE);
    assign grant_o = grant_q;

    // Split the flat per-master payload buses into arrays indexed by master.
    always_comb begin
        for (int i = 0; i < NoMstPorts; i++) begin
            ar_arr[i] = mst_ar_i[i*ArW +: ArW];
            aw_arr[i] = mst_aw_i[i*AwW +: AwW];
            w_arr[i]  = mst_w_i[i*WW +: WW];
        end
    end

    // Round-robin pick: the first requester found from rr_ptr_q upward, wrapping around.
    always_comb begin
        int s;
        s    = 0;
        pick = rr_ptr_q;
        // Search from the farthest offset down to the nearest, so the nearest requester is the last one written.
        for (int k = NoMstPorts - 1; k >= 0; k--) begin
            s = int'(rr_ptr_q) + k;
            if (s >= NoMstPorts) begin
                s = s - NoMstPorts;
            end
            if (req[IdxW'(s)]) begin
                pick = IdxW'(s);
            end
        end
    end

    // Next-state logic and channel routing for the granted master.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        is_read_d = is_read_q;

        mst_ar_ready_o = '0;
        mst_aw_ready_o = '0;
        mst_w_ready_o  = '0;
        mst_r_valid_o  = '0;
        mst_r_o        = '0;
        mst_r_last_o   = 1'b0;
        mst_b_valid_o  = '0;
        mst_b_o        = '0;
        ccu_ar_valid_o = 1'b0;
        ccu_ar_o       = '0;
        ccu_aw_valid_o = 1'b0;
        ccu_aw_o       = '0;
        ccu_w_valid_o  = 1'b0;
        ccu_w_o        = '0;
        ccu_w_last_o   = 1'b0;
        ccu_r_ready_o  = 1'b0;
        ccu_b_ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d   = pick;
                    // A master raising AR and AW together gets its read served first.
                    is_read_d = mst_ar_valid_i[pick];
                    rr_ptr_d  = (pick == IdxW'(NoMstPorts - 1)) ? '0 : pick + 1'b1;
                    state_d   = mst_ar_valid_i[pick] ? RD_ADDR : WR_ADDR;
                end
            end

            // The address phase forwards AR or AW, depending on the direction registered at grant.
            RD_ADDR, WR_ADDR: begin
                if (is_read_q) begin
                    ccu_ar_valid_o          = mst_ar_valid_i[grant_q];
                    ccu_ar_o                = ar_arr[grant_q];
                    mst_ar_ready_o[grant_q] = ccu_ar_ready_i;
                    if (mst_ar_valid_i[grant_q] && ccu_ar_ready_i) begin
                        state_d = RD_DATA;
                    end
                end else begin
                    ccu_aw_valid_o          = mst_aw_valid_i[grant_q];
                    ccu_aw_o                = aw_arr[grant_q];
                    mst_aw_ready_o[grant_q] = ccu_aw_ready_i;
                    if (mst_aw_valid_i[grant_q] && ccu_aw_ready_i) begin
                        state_d = WR_DATA;
                    end
                end
            end

            RD_DATA: begin
                mst_r_valid_o[grant_q] = ccu_r_valid_i;
                ccu_r_ready_o          = mst_r_ready_i[grant_q];
                mst_r_o                = ccu_r_i;
                mst_r_last_o           = ccu_r_last_i;
                if (ccu_r_valid_i && mst_r_ready_i[grant_q] && ccu_r_last_i) begin
                    state_d = IDLE;
                end
            end

            WR_DATA: begin
                ccu_w_valid_o          = mst_w_valid_i[grant_q];
                ccu_w_o                = w_arr[grant_q];
                ccu_w_last_o           = mst_w_last_i[grant_q];
                mst_w_ready_o[grant_q] = ccu_w_ready_i;
                if (mst_w_valid_i[grant_q] && ccu_w_ready_i && mst_w_last_i[grant_q]) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                mst_b_valid_o[grant_q] = ccu_b_valid_i;
                ccu_b_ready_o          = mst_b_ready_i[grant_q];
                mst_b_o                = ccu_b_i;
                if (ccu_b_valid_i && mst_b_ready_i[grant_q]) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and direction registers. Reset is synchronous and drops any in-flight beat.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            is_read_q <= is_read_d;
        end
    end

endmodule

// File: tb/tb_ccu_mst_arbiter.sv
// Testbench for ccu_mst_arbiter. A table of per-cycle vectors covers arbitration
// order, wrap-around, read-before-write and a stalled len-3 write. Hand-written
// sequences then cover R backpressure and a reset taken in the middle of a burst.
module tb_ccu_mst_arbiter;

    localparam int N   = 4;
    localparam int ArW = 64;
    localparam int AwW = 64;
    localparam int WW  = 73;
    localparam int RW  = 70;
    localparam int BW  = 6;

    localparam logic [RW-1:0] R_PAY0 = 70'h2A_1234_5678_9ABC_DEF0;
    localparam logic [RW-1:0] R_PAY1 = 70'h15_0FED_CBA9_8765_4321;
    localparam logic [BW-1:0] B_PAY  = 6'h2B;

    logic clk = 1'b0;
    logic rst_i;

    logic [N-1:0]      mst_ar_valid_i, mst_ar_ready_o;
    logic [N*ArW-1:0]  mst_ar_i;
    logic [N-1:0]      mst_aw_valid_i, mst_aw_ready_o;
    logic [N*AwW-1:0]  mst_aw_i;
    logic [N-1:0]      mst_w_valid_i, mst_w_ready_o;
    logic [N*WW-1:0]   mst_w_i;
    logic [N-1:0]      mst_w_last_i;
    logic [N-1:0]      mst_r_valid_o, mst_r_ready_i;
    logic [RW-1:0]     mst_r_o;
    logic              mst_r_last_o;
    logic [N-1:0]      mst_b_valid_o, mst_b_ready_i;
    logic [BW-1:0]     mst_b_o;
    logic              ccu_ar_valid_o, ccu_ar_ready_i;
    logic [ArW-1:0]    ccu_ar_o;
    logic              ccu_aw_valid_o, ccu_aw_ready_i;
    logic [AwW-1:0]    ccu_aw_o;
    logic              ccu_w_valid_o, ccu_w_ready_i;
    logic [WW-1:0]     ccu_w_o;
    logic              ccu_w_last_o;
    logic              ccu_r_valid_i, ccu_r_ready_o;
    logic [RW-1:0]     ccu_r_i;
    logic              ccu_r_last_i;
    logic              ccu_b_valid_i, ccu_b_ready_o;
    logic [BW-1:0]     ccu_b_i;
    logic              busy_o;
    logic [1:0]        grant_o;

    logic [ArW-1:0] ar_pay [N];
    logic [AwW-1:0] aw_pay [N];
    logic [WW-1:0]  w_pay  [N];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ccu_mst_arbiter #(
        .NoMstPorts(N), .ArW(ArW), .AwW(AwW), .WW(WW), .RW(RW), .BW(BW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .mst_ar_valid_i (mst_ar_valid_i),
        .mst_ar_ready_o (mst_ar_ready_o),
        .mst_ar_i       (mst_ar_i),
        .mst_aw_valid_i (mst_aw_valid_i),
        .mst_aw_ready_o (mst_aw_ready_o),
        .mst_aw_i       (mst_aw_i),
        .mst_w_valid_i  (mst_w_valid_i),
        .mst_w_ready_o  (mst_w_ready_o),
        .mst_w_i        (mst_w_i),
        .mst_w_last_i   (mst_w_last_i),
        .mst_r_valid_o  (mst_r_valid_o),
        .mst_r_ready_i  (mst_r_ready_i),
        .mst_r_o        (mst_r_o),
        .mst_r_last_o   (mst_r_last_o),
        .mst_b_valid_o  (mst_b_valid_o),
        .mst_b_ready_i  (mst_b_ready_i),
        .mst_b_o        (mst_b_o),
        .ccu_ar_valid_o (ccu_ar_valid_o),
        .ccu_ar_ready_i (ccu_ar_ready_i),
        .ccu_ar_o       (ccu_ar_o),
        .ccu_aw_valid_o (ccu_aw_valid_o),
        .ccu_aw_ready_i (ccu_aw_ready_i),
        .ccu_aw_o       (ccu_aw_o),
        .ccu_w_valid_o  (ccu_w_valid_o),
        .ccu_w_ready_i  (ccu_w_ready_i),
        .ccu_w_o        (ccu_w_o),
        .ccu_w_last_o   (ccu_w_last_o),
        .ccu_r_valid_i  (ccu_r_valid_i),
        .ccu_r_ready_o  (ccu_r_ready_o),
        .ccu_r_i        (ccu_r_i),
        .ccu_r_last_i   (ccu_r_last_i),
        .ccu_b_valid_i  (ccu_b_valid_i),
        .ccu_b_ready_o  (ccu_b_ready_o),
        .ccu_b_i        (ccu_b_i),
        .busy_o         (busy_o),
        .grant_o        (grant_o)
    );

    // One cycle of stimulus plus the outputs expected during that cycle.
    typedef struct {
        logic [3:0]  ar_v, aw_v, w_v, w_last, r_rdy, b_rdy;
        logic [2:0]  ccu_rdy;   // {ar_ready, aw_ready, w_ready}
        logic [2:0]  ccu_rsp;   // {r_valid, r_last, b_valid}
        logic        busy;
        logic [1:0]  grant;
        logic [11:0] mst_rdy;   // {mst_ar_ready, mst_aw_ready, mst_w_ready}
        logic [7:0]  mst_vld;   // {mst_r_valid, mst_b_valid}
        logic [5:0]  ccu_out;   // {ar_valid, aw_valid, w_valid, w_last, r_ready, b_ready}
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    function automatic vec_t mk(
        input logic [3:0] ar_v, aw_v, w_v, w_last, r_rdy, b_rdy,
        input logic [2:0] ccu_rdy, ccu_rsp,
        input logic busy, input logic [1:0] grant,
        input logic [11:0] mst_rdy, input logic [7:0] mst_vld, input logic [5:0] ccu_out);
        vec_t r;
        r.ar_v = ar_v; r.aw_v = aw_v; r.w_v = w_v; r.w_last = w_last;
        r.r_rdy = r_rdy; r.b_rdy = b_rdy; r.ccu_rdy = ccu_rdy; r.ccu_rsp = ccu_rsp;
        r.busy = busy; r.grant = grant; r.mst_rdy = mst_rdy; r.mst_vld = mst_vld;
        r.ccu_out = ccu_out;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        mst_ar_valid_i = x.ar_v;
        mst_aw_valid_i = x.aw_v;
        mst_w_valid_i  = x.w_v;
        mst_w_last_i   = x.w_last;
        mst_r_ready_i  = x.r_rdy;
        mst_b_ready_i  = x.b_rdy;
        ccu_ar_ready_i = x.ccu_rdy[2];
        ccu_aw_ready_i = x.ccu_rdy[1];
        ccu_w_ready_i  = x.ccu_rdy[0];
        ccu_r_valid_i  = x.ccu_rsp[2];
        ccu_r_last_i   = x.ccu_rsp[1];
        ccu_b_valid_i  = x.ccu_rsp[0];
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ar_pay[i] = {16'hA5A5, 44'h0, 4'(i + 1)};
            aw_pay[i] = {16'h5A5A, 44'h0, 4'(i + 1)};
            w_pay[i]  = {9'h155, 60'h0, 4'(i + 1)};
            mst_ar_i[i*ArW +: ArW] = ar_pay[i];
            mst_aw_i[i*AwW +: AwW] = aw_pay[i];
            mst_w_i[i*WW +: WW]    = w_pay[i];
        end
        ccu_r_i = R_PAY0;
        ccu_b_i = B_PAY;
        rst_i   = 1'b1;
        apply(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 1'b0, 2'd0, 12'h0, 8'h0, 6'h0));

        // Four simultaneous AR requests are granted 0,1,2,3; each gets one R beat.
        vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd0, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd0, 12'h100, 8'h00, 6'h20));
        vecs.push_back(mk(4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd0, 12'h000, 8'h10, 6'h02));
        vecs.push_back(mk(4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd0, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd1, 12'h200, 8'h00, 6'h20));
        vecs.push_back(mk(4'hC, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd1, 12'h000, 8'h20, 6'h02));
        vecs.push_back(mk(4'hC, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd1, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'hC, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd2, 12'h400, 8'h00, 6'h20));
        vecs.push_back(mk(4'h8, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd2, 12'h000, 8'h40, 6'h02));
        vecs.push_back(mk(4'h8, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd2, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h8, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd3, 12'h800, 8'h00, 6'h20));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd3, 12'h000, 8'h80, 6'h02));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd3, 12'h000, 8'h00, 6'h00));
        // Lone master 1, then lone master 0 (wrap-around), then 0 and 1 together (pointer now at 1).
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd3, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd1, 12'h200, 8'h00, 6'h20));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd1, 12'h000, 8'h20, 6'h02));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd1, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd0, 12'h100, 8'h00, 6'h20));
        vecs.push_back(mk(4'h3, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd0, 12'h000, 8'h10, 6'h02));
        vecs.push_back(mk(4'h3, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd0, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h3, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd1, 12'h200, 8'h00, 6'h20));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd1, 12'h000, 8'h20, 6'h02));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd1, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd0, 12'h100, 8'h00, 6'h20));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b1, 2'd0, 12'h000, 8'h10, 6'h02));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b110, 1'b0, 2'd0, 12'h000, 8'h00, 6'h00));
        // Master 2 raises AR+AW with master 3 on AW: read of 2, then write of 3 (len 0), then write of 2 (len 3).
        vecs.push_back(mk(4'h4, 4'hC, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b111, 1'b0, 2'd0, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h4, 4'hC, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b111, 1'b1, 2'd2, 12'h400, 8'h00, 6'h20));
        vecs.push_back(mk(4'h0, 4'hC, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b111, 1'b1, 2'd2, 12'h000, 8'h40, 6'h02));
        vecs.push_back(mk(4'h0, 4'hC, 4'h4, 4'h0, 4'hF, 4'h0, 3'b111, 3'b001, 1'b0, 2'd2, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h0, 4'hC, 4'hC, 4'h8, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd3, 12'h080, 8'h00, 6'h10));
        vecs.push_back(mk(4'h0, 4'h4, 4'hC, 4'h8, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd3, 12'h008, 8'h00, 6'h0C));
        vecs.push_back(mk(4'h0, 4'h4, 4'h4, 4'h0, 4'hF, 4'hF, 3'b111, 3'b001, 1'b1, 2'd3, 12'h000, 8'h08, 6'h01));
        vecs.push_back(mk(4'h0, 4'h4, 4'h4, 4'h0, 4'hF, 4'h0, 3'b111, 3'b001, 1'b0, 2'd3, 12'h000, 8'h00, 6'h00));
        vecs.push_back(mk(4'h0, 4'h4, 4'h4, 4'h0, 4'hF, 4'h0, 3'b001, 3'b001, 1'b1, 2'd2, 12'h000, 8'h00, 6'h10));
        vecs.push_back(mk(4'h0, 4'h4, 4'h4, 4'h0, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd2, 12'h040, 8'h00, 6'h10));
        vecs.push_back(mk(4'h0, 4'h0, 4'h4, 4'h0, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd2, 12'h004, 8'h00, 6'h08));
        vecs.push_back(mk(4'h0, 4'h0, 4'h4, 4'h0, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd2, 12'h004, 8'h00, 6'h08));
        vecs.push_back(mk(4'h0, 4'h0, 4'h4, 4'h0, 4'hF, 4'h0, 3'b110, 3'b001, 1'b1, 2'd2, 12'h000, 8'h00, 6'h08));
        vecs.push_back(mk(4'h0, 4'h0, 4'h4, 4'h0, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd2, 12'h004, 8'h00, 6'h08));
        vecs.push_back(mk(4'h0, 4'h0, 4'h4, 4'h4, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd2, 12'h004, 8'h00, 6'h0C));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 3'b111, 3'b001, 1'b1, 2'd2, 12'h000, 8'h04, 6'h00));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 3'b111, 3'b001, 1'b1, 2'd2, 12'h000, 8'h04, 6'h01));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 1'b0, 2'd2, 12'h000, 8'h00, 6'h00));

        // Reset state while rst_i is still high.
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy_o, 1'b0);
        check("reset grant", grant_o, 2'd0);
        check("reset ready/valid",
              {mst_ar_ready_o, mst_aw_ready_o, mst_w_ready_o, mst_r_valid_o, mst_b_valid_o,
               ccu_ar_valid_o, ccu_aw_valid_o, ccu_w_valid_o, ccu_r_ready_o, ccu_b_ready_o}, '0);
        check("reset payloads", |{ccu_ar_o, ccu_aw_o, ccu_w_o, ccu_w_last_o, mst_r_o, mst_r_last_o, mst_b_o}, 1'b0);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v);
            @(negedge clk);
            check($sformatf("row%0d busy", i), busy_o, v.busy);
            check($sformatf("row%0d grant", i), grant_o, v.grant);
            check($sformatf("row%0d mst_ready", i), {mst_ar_ready_o, mst_aw_ready_o, mst_w_ready_o}, v.mst_rdy);
            check($sformatf("row%0d mst_valid", i), {mst_r_valid_o, mst_b_valid_o}, v.mst_vld);
            check($sformatf("row%0d ccu_ctl", i),
                  {ccu_ar_valid_o, ccu_aw_valid_o, ccu_w_valid_o, ccu_w_last_o, ccu_r_ready_o, ccu_b_ready_o},
                  v.ccu_out);
            if (v.ccu_out[5]) check($sformatf("row%0d ccu_ar", i), ccu_ar_o, ar_pay[v.grant]);
            if (v.ccu_out[4]) check($sformatf("row%0d ccu_aw", i), ccu_aw_o, aw_pay[v.grant]);
            if (v.ccu_out[3]) check($sformatf("row%0d ccu_w", i), ccu_w_o, w_pay[v.grant]);
            if (v.mst_vld[7:4] != 4'h0) check($sformatf("row%0d mst_r", i), {mst_r_last_o, mst_r_o}, {v.ccu_rsp[1], R_PAY0});
            if (v.mst_vld[3:0] != 4'h0) check($sformatf("row%0d mst_b", i), mst_b_o, B_PAY);
            if (!v.busy) check($sformatf("row%0d idle payloads", i), |{ccu_ar_o, ccu_aw_o, ccu_w_o, mst_r_o, mst_b_o}, 1'b0);
            @(posedge clk);
            #1;
        end

        // Master 1 read with AR stall, then R backpressure held for 5 cycles (pointer at 3 -> grant 1).
        mst_ar_valid_i = 4'h2;
        ccu_ar_ready_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ar stall valid", ccu_ar_valid_o, 1'b1);
        check("ar stall payload", ccu_ar_o, ar_pay[1]);
        check("ar stall ready", mst_ar_ready_o, 4'h0);
        ccu_ar_ready_i = 1'b1;
        #1;
        check("ar ready pass", mst_ar_ready_o, 4'h2);
        @(posedge clk);
        #1;
        mst_ar_valid_i = 4'h0;
        ccu_r_valid_i  = 1'b1;
        ccu_r_last_i   = 1'b0;
        ccu_r_i        = R_PAY0;
        mst_r_ready_i  = 4'hD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("r bp%0d ccu_r_ready", c), ccu_r_ready_o, 1'b0);
            check($sformatf("r bp%0d r_valid", c), mst_r_valid_o, 4'h2);
            check($sformatf("r bp%0d payload", c), mst_r_o, R_PAY0);
            @(posedge clk);
            #1;
        end
        mst_r_ready_i = 4'hF;
        @(negedge clk);
        check("r beat0 ready", ccu_r_ready_o, 1'b1);
        check("r beat0 payload", mst_r_o, R_PAY0);
        @(posedge clk);
        #1;
        ccu_r_i = R_PAY1;
        @(negedge clk);
        check("r beat1 busy", busy_o, 1'b1);
        check("r beat1 payload", mst_r_o, R_PAY1);

        // Synchronous reset in the middle of the read burst.
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", busy_o, 1'b0);
        check("midrst grant", grant_o, 2'd0);
        check("midrst r_valid", mst_r_valid_o, 4'h0);
        check("midrst ccu_r_ready", ccu_r_ready_o, 1'b0);
        check("midrst r payload", mst_r_o, '0);
        rst_i          = 1'b0;
        ccu_r_valid_i  = 1'b0;
        mst_ar_valid_i = 4'h5;
        @(posedge clk);
        #1;
        // The pointer must be back at 0, so master 0 wins over master 2.
        check("post-rst busy", busy_o, 1'b1);
        check("post-rst grant", grant_o, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ccu_mst_arbiter.md
Name: ccu_mst_arbiter

Overview:
- Shares the single, non-pipelined CCU coherency FSM port among NoMstPorts ACE masters.
- Arbitrates AR/AW requests round-robin and grants one whole transaction at a time.
- Forwards the granted master's AR/AW/W to the CCU and routes R/B back to that master only.
- Sits between the master-side ports and the CCU FSM's request input.

Parameters:
- NoMstPorts, 4, number of requesting masters (>=2).
- ArW, 64, AR payload width (addr, prot, snoop, id, len, ...).
- AwW, 64, AW payload width.
- WW, 73, W payload width excluding last.
- RW, 70, R payload width excluding last.
- BW, 6, B payload width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- mst_ar_valid_i / mst_ar_ready_o  in/out  NoMstPorts  per-master AR handshake.
- mst_ar_i  in  NoMstPorts*ArW  per-master AR payload.
- mst_aw_valid_i / mst_aw_ready_o  in/out  NoMstPorts  per-master AW handshake.
- mst_aw_i  in  NoMstPorts*AwW  per-master AW payload.
- mst_w_valid_i / mst_w_ready_o  in/out  NoMstPorts  per-master W handshake.
- mst_w_i  in  NoMstPorts*WW  W payload.
- mst_w_last_i  in  NoMstPorts  W last.
- mst_r_valid_o / mst_r_ready_i  out/in  NoMstPorts  R handshake.
- mst_r_o  out  RW  R payload, broadcast to all masters.
- mst_r_last_o  out  1  R last.
- mst_b_valid_o / mst_b_ready_i  out/in  NoMstPorts  B handshake.
- mst_b_o  out  BW  B payload, broadcast.
- ccu_ar_valid_o / ccu_ar_ready_i, ccu_ar_o  out/in, out  1, ArW  AR to CCU.
- ccu_aw_valid_o / ccu_aw_ready_i, ccu_aw_o  out/in, out  1, AwW  AW to CCU.
- ccu_w_valid_o / ccu_w_ready_i, ccu_w_o, ccu_w_last_o  out/in, out, out  1, WW, 1  W to CCU.
- ccu_r_valid_i / ccu_r_ready_o, ccu_r_i, ccu_r_last_i  in/out, in, in  1, RW, 1  R from CCU.
- ccu_b_valid_i / ccu_b_ready_o, ccu_b_i  in/out, in  1, BW  B from CCU.
- busy_o  out  1  state != IDLE.
- grant_o  out  $clog2(NoMstPorts)  current grant index.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- Reset (rst_i high at a clock edge): state=IDLE, rr_ptr=0, grant=0, is_read=0. This applies from any state, mid-transaction included, and in-flight beats are dropped.
- Output reset values: all valid/ready outputs 0, payloads 0, busy_o=0, grant_o=0.
- Combinational default: every output valid/ready is 0 and payloads are 0 unless the state rules below drive them.
- IDLE, request and pick:
  - req[i] = mst_ar_valid_i[i] | mst_aw_valid_i[i].
  - If req != 0, pick the first set index searching rr_ptr, rr_ptr+1, ... modulo NoMstPorts.
  - Register grant=pick and is_read=mst_ar_valid_i[pick]; AR wins over AW within the same master.
  - Set rr_ptr=(pick+1) mod NoMstPorts.
  - Go to RD_ADDR if is_read, else WR_ADDR.
- No ready is asserted in IDLE. Arbitration latency is 1 cycle, so earliest ccu_ar_valid_o is the cycle after the request is seen.
- RD_ADDR:
  - ccu_ar_valid_o = mst_ar_valid_i[grant]; ccu_ar_o = mst_ar_i[grant].
  - mst_ar_ready_o[grant] = ccu_ar_ready_i.
  - On handshake go to RD_DATA.
- RD_DATA:
  - mst_r_valid_o[grant] = ccu_r_valid_i; ccu_r_ready_o = mst_r_ready_i[grant].
  - mst_r_o / mst_r_last_o = ccu_r_i / ccu_r_last_i.
  - On a handshake with last=1 go to IDLE. Other beats stay in RD_DATA.
- WR_ADDR: same as RD_ADDR on the AW channel; handshake goes to WR_DATA.
- WR_DATA:
  - W is passed from grant only; non-granted mst_w_ready_o stay 0.
  - On a handshake with mst_w_last_i[grant]=1 go to WR_RESP.
  - A W beat presented before its AW is held off (ready=0) until WR_DATA.
- WR_RESP:
  - mst_b_valid_o[grant] = ccu_b_valid_i; ccu_b_ready_o = mst_b_ready_i[grant].
  - On handshake go to IDLE.
- At most one transaction is outstanding. Next arbitration happens in the IDLE cycle after completion, so there are no back-to-back grants without an IDLE cycle.
- Non-granted masters never see valid or ready asserted.
- Valid/payload from a master must stay stable until its handshake, per AXI. The arbiter does not re-arbitrate inside a transaction.
- Simultaneous case: a master dropping mst_ar_valid_i[grant] in RD_ADDR is an AXI violation. The arbiter simply waits (ccu_ar_valid_o follows input) with no deadlock recovery.
- rr_ptr only advances on a grant. A lone requester at any index is granted regardless of rr_ptr.

Test Plan:
- Reset, then all four masters raise AR in the same cycle -> grants in order 0,1,2,3. Each sees exactly one R beat (len 0) routed to it only; the other mst_r_valid_o stay 0.
- After grant=1 completes, only master 0 requests -> grant 0 (wrap-around). rr_ptr becomes 1.
- Master 2 raises AR and AW together -> read performed first. The next IDLE grants master 3 if it is requesting, else master 2's write.
- Write, len 3: AW handshake, then 4 W beats with last on the 4th, then B -> state sequence WR_ADDR, WR_DATA×4, WR_RESP, IDLE. Early W from master 2 is stalled with ready=0.
- R backpressure: mst_r_ready_i[grant]=0 for 5 cycles -> ccu_r_ready_o=0 for those cycles, payload unchanged, no beat lost.
- rst_i asserted in RD_DATA mid-burst -> next cycle all valids 0, busy_o=0, grant_o=0, rr_ptr=0.
